sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  Shares the single Avalon-MM SDRAM slave port (new_sdram_controller_0_s1) between one record
//  writer and N_RD playback readers inside AcappellaCore. Latches one request at a time, holds
//  it stable across waitrequest and tags each accepted read. Routes pipelined readdata back to
//  the issuing reader in order. Sits between the play/record engines and the SDRAM controller.
// PARAMETERS
//  N_RD      3   number of playback reader ports (1..8)
//  MAX_PEND  4   max reads accepted by SDRAM but not yet returned (power of 2, 2..16)
//  AW        23  SDRAM word address width
// PORTS
//  i_clk         in   1         system clock
//  i_rst         in   1         synchronous, active-high reset
//  i_wr_req      in   1         writer request; hold with addr/data until o_wr_ack
//  i_wr_addr     in   AW        write word address
//  i_wr_data     in   32        write data
//  o_wr_ack      out  1         1-cycle pulse: write request latched
//  i_rd_req      in   N_RD      reader requests; hold with addr until matching o_rd_ack bit
//  i_rd_addr     in   N_RD*AW   reader k address at [k*AW +: AW]
//  o_rd_ack      out  N_RD      1-cycle one-hot pulse: read request latched
//  o_rd_data     out  32        returned read data (shared bus)
//  o_rd_valid    out  N_RD      one-hot: o_rd_data belongs to reader k this cycle
//  o_err         out  1         sticky: readdatavalid seen with no read outstanding
//  avm_address   out  AW        -> new_sdram_controller_0_s1_address
//  avm_byteen_n  out  4         -> byteenable_n; constant 4'b0000
//  avm_cs        out  1         -> chipselect
//  avm_wdata     out  32        -> writedata
//  avm_read_n    out  1         -> read_n (active low)
//  avm_write_n   out  1         -> write_n (active low)
//  avm_rdata     in   32        <- readdata
//  avm_rvalid    in   1         <- readdatavalid
//  avm_wait      in   1         <- waitrequest
// BEHAVIOUR
//  - Reset: state IDLE; avm_cs=0, avm_read_n=1, avm_write_n=1, avm_address=0, avm_wdata=0;
//    all acks/valids 0; o_rd_data=0; o_err=0; tag FIFO empty; RR pointer=0.
//    Reset mid-command abandons it; no ack is emitted for it.
//  - FSM: IDLE -> CMD -> IDLE. Max throughput one command per 2 cycles.
//  - IDLE: a read is eligible only when pending < MAX_PEND. Writer has fixed priority over
//    readers. Readers use round-robin starting at (last granted reader + 1) mod N_RD.
//    On grant: register addr/data/type, pulse the matching ack, go to CMD (all on one edge).
//  - CMD: avm_cs=1, plus read_n=0 or write_n=0. Address and data are held stable.
//    Accepted at the first edge with avm_wait=0: a read pushes its reader index to the tag
//    FIFO. Then go to IDLE and deassert cs/read_n/write_n.
//  - Return: avm_rvalid=1 pops the tag FIFO head. The next cycle drives o_rd_data=avm_rdata
//    and o_rd_valid[tag]=1 (latency 1). Returns are strictly in issue order.
//  - Simultaneous tag push (accept) and pop (return) in one cycle: legal; count unchanged.
//  - avm_rvalid with FIFO empty: data dropped, no o_rd_valid, o_err set until i_rst.
//  - Full (pending==MAX_PEND): reads stall in IDLE; writes still granted.
//  - Requester dropping req before its ack: allowed, provided it happens before the grant
//    edge; after the grant edge the latched command completes regardless.
// CONFIGURATION
//  SDRAM_ARB_WR_FAIR_EN defined: the writer joins round-robin as slot N_RD.
//    Order is 0..N_RD-1, W, 0..., so playback cannot starve behind continuous recording.
//  Undefined (default): writer has strict priority as described above.
// TESTING
//  1 Reset 2 cycles, no requests -> cs=0, read_n=1, write_n=1, byteen_n=0, acks/valids 0, o_err=0.
//  2 wr_req, addr=23'h10, data=32'hDEADBEEF, wait=0 -> o_wr_ack pulse; next cycle cs=1,
//    write_n=0, addr=0x10; back to IDLE one cycle later.
//  3 As test 2 but wait=1 for 3 cycles -> cmd held 4 cycles unchanged, exactly one ack.
//  4 rd_req=3'b111, wait=0 -> grants 0,1,2,0. Then rvalid with rdata=32'd123546464 ->
//    o_rd_valid=3'b001 one cycle later, then 3'b010 on the next return.
//  5 MAX_PEND=4, rvalid=0, readers requesting -> exactly 4 reads issued, then stall. wr_req
//    still granted. One rvalid -> one more read issued.
//  6 wr_req and rd_req[0] held -> default: W,W,W... (reader starved).
//    With SDRAM_ARB_WR_FAIR_EN: alternating 0,W,0,W.
//  7 rvalid=1 right after reset -> o_err=1 next cycle, o_rd_valid stays 0; cleared by i_rst.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter_if
//   Bundles every signal of the SDRAM port arbiter except clock and reset:
//   the record-writer request channel, the N_RD playback-reader channels,
//   the shared read-return bus and the Avalon-MM master towards the SDRAM
//   controller slave port.
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the Avalon master)
//     master - the surrounding system's view (requesters + SDRAM controller)
//   Parameters: N_RD (reader ports), AW (SDRAM word address width).
// ---------------------------------------------------------------------------
interface sdram_port_arbiter_if #(
   parameter int N_RD = 3,
   parameter int AW   = 23
);
   // writer channel
   logic                 i_wr_req;
   logic [AW-1:0]        i_wr_addr;
   logic [31:0]          i_wr_data;
   logic                 o_wr_ack;
   // reader channels
   logic [N_RD-1:0]      i_rd_req;
   logic [N_RD*AW-1:0]   i_rd_addr;
   logic [N_RD-1:0]      o_rd_ack;
   logic [31:0]          o_rd_data;
   logic [N_RD-1:0]      o_rd_valid;
   logic                 o_err;
   // Avalon-MM master towards the SDRAM controller
   logic [AW-1:0]        avm_address;
   logic [3:0]           avm_byteen_n;
   logic                 avm_cs;
   logic [31:0]          avm_wdata;
   logic                 avm_read_n;
   logic                 avm_write_n;
   logic [31:0]          avm_rdata;
   logic                 avm_rvalid;
   logic                 avm_wait;

   modport slave (
      input  i_wr_req, i_wr_addr, i_wr_data,
      output o_wr_ack,
      input  i_rd_req, i_rd_addr,
      output o_rd_ack, o_rd_data, o_rd_valid, o_err,
      output avm_address, avm_byteen_n, avm_cs, avm_wdata, avm_read_n, avm_write_n,
      input  avm_rdata, avm_rvalid, avm_wait
   );

   modport master (
      output i_wr_req, i_wr_addr, i_wr_data,
      input  o_wr_ack,
      output i_rd_req, i_rd_addr,
      input  o_rd_ack, o_rd_data, o_rd_valid, o_err,
      input  avm_address, avm_byteen_n, avm_cs, avm_wdata, avm_read_n, avm_write_n,
      output avm_rdata, avm_rvalid, avm_wait
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//   Shares one Avalon-MM SDRAM slave port between a record writer and N_RD
//   playback readers. One request is latched at a time and held stable on the
//   Avalon bus until waitrequest drops. Every accepted read pushes its reader
//   index into a tag FIFO; each readdatavalid pops the head so returned data
//   is steered to the issuing reader, strictly in issue order, one cycle later.
//   Ports:
//     i_clk, i_rst  - clock, synchronous active-high reset
//     bus (slave)   - writer/reader request channels, read-return bus,
//                     sticky error flag and the Avalon master signals
//   Parameters: N_RD (1..8), MAX_PEND (power of 2, 2..16), AW.
//   Build option: define SDRAM_ARB_WR_FAIR_EN to put the writer into the
//   round-robin rotation as slot N_RD instead of giving it strict priority.
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
   parameter int N_RD     = 3,
   parameter int MAX_PEND = 4,
   parameter int AW       = 23
) (
   input  logic                i_clk,
   input  logic                i_rst,
   sdram_port_arbiter_if.slave bus
);

   localparam int IW = (N_RD > 1) ? $clog2(N_RD) : 1;   // reader tag width
   localparam int PW = $clog2(MAX_PEND);                 // FIFO pointer width
   localparam int RW = $clog2(N_RD + 1);                 // RR pointer width
   localparam logic [PW:0] CNT_MAX = (PW + 1)'(MAX_PEND);

`ifdef SDRAM_ARB_WR_FAIR_EN
   localparam int   RR_N      = N_RD + 1;
   localparam logic WR_STRICT = 1'b0;
`else
   localparam int   RR_N      = N_RD;
   localparam logic WR_STRICT = 1'b1;
`endif

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_CMD  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              is_rd_q, is_rd_d;
   logic [IW-1:0]     tag_q, tag_d;
   logic              cs_q, cs_d;
   logic              read_n_q, read_n_d;
   logic              write_n_q, write_n_d;
   logic              wr_ack_q, wr_ack_d;
   logic [N_RD-1:0]   rd_ack_q, rd_ack_d;
   logic [RW-1:0]     rr_q, rr_d;

   logic [IW-1:0]     tag_mem_q [MAX_PEND];
   logic [PW-1:0]     wptr_q, wptr_d;
   logic [PW-1:0]     rptr_q, rptr_d;
   logic [PW:0]       cnt_q, cnt_d;
   logic [31:0]       rd_data_q, rd_data_d;
   logic [N_RD-1:0]   rd_valid_q, rd_valid_d;
   logic              err_q, err_d;

   logic              rd_ok_s;
   logic [N_RD:0]     req_ext_s;
   logic              gnt_wr_s;
   logic              gnt_rd_s;
   logic [IW-1:0]     gnt_idx_s;
   logic [RW-1:0]     rr_nxt_s;
   logic              push_s;
   logic              pop_s;
   logic [IW-1:0]     head_tag_s;

   // Rotating slot index: base and off are both below n, so one subtract wraps.
   function automatic int wrap_add(input int base, input int off, input int n);
      int s;
      s = base + off;
      s = (s >= n) ? s - n : s;
      return s;
   endfunction

   // Grant selection: writer priority (or rotation slot) plus reader round-robin.
   always_comb begin
      int   slot_v;
      int   sel_v;
      logic hit_v;
      gnt_wr_s  = 1'b0;
      gnt_rd_s  = 1'b0;
      gnt_idx_s = '0;
      rr_nxt_s  = rr_q;
      rd_ok_s   = (cnt_q < CNT_MAX);
      req_ext_s = {bus.i_wr_req & ~WR_STRICT, bus.i_rd_req & {N_RD{rd_ok_s}}};
      sel_v     = 0;
      hit_v     = 1'b0;
      // Walk from the farthest slot back to the pointer so the nearest request wins.
      for (int i = RR_N - 1; i >= 0; i--) begin
         slot_v = wrap_add(int'(rr_q), i, RR_N);
         hit_v  = hit_v | req_ext_s[RW'(slot_v)];
         sel_v  = req_ext_s[RW'(slot_v)] ? slot_v : sel_v;
      end
      if (WR_STRICT && bus.i_wr_req) begin
         gnt_wr_s = 1'b1;
      end else if (hit_v && (sel_v == N_RD)) begin
         gnt_wr_s = 1'b1;
         rr_nxt_s = RW'(wrap_add(sel_v, 1, RR_N));
      end else if (hit_v) begin
         gnt_rd_s  = 1'b1;
         gnt_idx_s = IW'(sel_v);
         rr_nxt_s  = RW'(wrap_add(sel_v, 1, RR_N));
      end else begin
         gnt_wr_s = 1'b0;
      end
   end

   // Command FSM next state: latch a grant in IDLE, hold the command in CMD.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      is_rd_d   = is_rd_q;
      tag_d     = tag_q;
      cs_d      = cs_q;
      read_n_d  = read_n_q;
      write_n_d = write_n_q;
      rr_d      = rr_q;
      wr_ack_d  = 1'b0;
      rd_ack_d  = '0;
      push_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_wr_s) begin
               addr_d    = bus.i_wr_addr;
               wdata_d   = bus.i_wr_data;
               is_rd_d   = 1'b0;
               cs_d      = 1'b1;
               write_n_d = 1'b0;
               read_n_d  = 1'b1;
               wr_ack_d  = 1'b1;
               rr_d      = rr_nxt_s;
               state_d   = ST_CMD;
            end else if (gnt_rd_s) begin
               addr_d              = bus.i_rd_addr[int'(gnt_idx_s) * AW +: AW];
               is_rd_d             = 1'b1;
               tag_d               = gnt_idx_s;
               cs_d                = 1'b1;
               read_n_d            = 1'b0;
               write_n_d           = 1'b1;
               rd_ack_d[gnt_idx_s] = 1'b1;
               rr_d                = rr_nxt_s;
               state_d             = ST_CMD;
            end else begin
               cs_d      = 1'b0;
               read_n_d  = 1'b1;
               write_n_d = 1'b1;
            end
         end
         ST_CMD: begin
            if (!bus.avm_wait) begin
               push_s    = is_rd_q;
               cs_d      = 1'b0;
               read_n_d  = 1'b1;
               write_n_d = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_CMD;
            end
         end
         default: begin
            cs_d      = 1'b0;
            read_n_d  = 1'b1;
            write_n_d = 1'b1;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Tag FIFO bookkeeping and read-return steering; pop happens before push,
   // so a return arriving with nothing outstanding is an error even if a read
   // is accepted on the same edge.
   always_comb begin
      pop_s      = bus.avm_rvalid & (cnt_q != '0);
      err_d      = err_q | (bus.avm_rvalid & (cnt_q == '0));
      head_tag_s = tag_mem_q[rptr_q];
      rd_data_d  = pop_s ? bus.avm_rdata : rd_data_q;
      for (int k = 0; k < N_RD; k++) begin
         rd_valid_d[k] = pop_s & (int'(head_tag_s) == k);
      end
      wptr_d = push_s ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop_s  ? rptr_q + PW'(1) : rptr_q;
      case ({push_s, pop_s})
         2'b10:   cnt_d = cnt_q + (PW + 1)'(1);
         2'b01:   cnt_d = cnt_q - (PW + 1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // FSM state and command/handshake registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_rd_q   <= 1'b0;
         tag_q     <= '0;
         cs_q      <= 1'b0;
         read_n_q  <= 1'b1;
         write_n_q <= 1'b1;
         wr_ack_q  <= 1'b0;
         rd_ack_q  <= '0;
         rr_q      <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         is_rd_q   <= is_rd_d;
         tag_q     <= tag_d;
         cs_q      <= cs_d;
         read_n_q  <= read_n_d;
         write_n_q <= write_n_d;
         wr_ack_q  <= wr_ack_d;
         rd_ack_q  <= rd_ack_d;
         rr_q      <= rr_d;
      end
   end

   // Tag FIFO storage and registered read-return outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < MAX_PEND; k++) begin
            tag_mem_q[k] <= '0;
         end
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= '0;
         err_q      <= 1'b0;
      end else begin
         if (push_s) begin
            tag_mem_q[wptr_q] <= tag_q;
         end
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         err_q      <= err_d;
      end
   end

   assign bus.o_wr_ack     = wr_ack_q;
   assign bus.o_rd_ack     = rd_ack_q;
   assign bus.o_rd_data    = rd_data_q;
   assign bus.o_rd_valid   = rd_valid_q;
   assign bus.o_err        = err_q;
   assign bus.avm_address  = addr_q;
   assign bus.avm_byteen_n = 4'b0000;
   assign bus.avm_cs       = cs_q;
   assign bus.avm_wdata    = wdata_q;
   assign bus.avm_read_n   = read_n_q;
   assign bus.avm_write_n  = write_n_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//   Drives the arbiter from requester/SDRAM stand-ins and compares every cycle
//   against a transaction-level model: one command in flight, a queue of
//   outstanding read tags, a round-robin pointer and a sticky error flag.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;
   localparam int N_RD     = 3;
   localparam int MAX_PEND = 4;
   localparam int AW       = 23;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sdram_port_arbiter_if #(.N_RD(N_RD), .AW(AW)) bus ();

   sdram_port_arbiter #(.N_RD(N_RD), .MAX_PEND(MAX_PEND), .AW(AW)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   bit            m_busy;
   bit            m_is_rd;
   int            m_tag;
   logic [AW-1:0] m_addr;
   logic [31:0]   m_wdata;
   int            m_rr;
   int            tq[$];
   bit            m_err;
   logic [31:0]   m_data;

   // observation / stimulus control
   int ack_log[$];
   int cs_cycles;
   int w_rearm, r_rearm, p_raise, p_drop;
   int exp4[4] = '{0, 1, 2, 0};

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, act, exp);
      end
   endtask

   task automatic pick(output int g);
      int s;
      bit eligible;
      g = -1;
      eligible = (tq.size() < MAX_PEND);
`ifdef SDRAM_ARB_WR_FAIR_EN
      for (int i = 0; i <= N_RD && g < 0; i++) begin
         s = (m_rr + i) % (N_RD + 1);
         if (s == N_RD) begin
            if (bus.i_wr_req) g = N_RD;
         end else if (eligible && bus.i_rd_req[s]) begin
            g = s;
         end
      end
      if (g >= 0) m_rr = (g + 1) % (N_RD + 1);
`else
      if (bus.i_wr_req) begin
         g = N_RD;
      end else if (eligible) begin
         for (int i = 0; i < N_RD && g < 0; i++) begin
            s = (m_rr + i) % N_RD;
            if (bus.i_rd_req[s]) g = s;
         end
         if (g >= 0) m_rr = (g + 1) % N_RD;
      end
`endif
   endtask

   // Predict the effect of the coming edge, clock it, then compare.
   task automatic step();
      logic            e_wr_ack;
      logic [N_RD-1:0] e_rd_ack;
      logic [N_RD-1:0] e_valid;
      bit              push;
      bit              was_rst;
      int              g;
      int              t;
      e_wr_ack = 1'b0;
      e_rd_ack = '0;
      e_valid  = '0;
      push     = 1'b0;
      was_rst  = rst;
      if (rst) begin
         m_busy = 0; m_is_rd = 0; m_tag = 0; m_addr = '0; m_wdata = '0;
         m_rr = 0; tq.delete(); m_err = 0; m_data = '0;
      end else begin
         if (!m_busy) begin
            pick(g);
            if (g == N_RD) begin
               m_busy = 1; m_is_rd = 0; m_addr = bus.i_wr_addr; m_wdata = bus.i_wr_data;
               e_wr_ack = 1'b1;
            end else if (g >= 0) begin
               m_busy = 1; m_is_rd = 1; m_tag = g; m_addr = bus.i_rd_addr[g*AW +: AW];
               e_rd_ack[g] = 1'b1;
            end
         end else if (!bus.avm_wait) begin
            push = m_is_rd;
            m_busy = 0;
         end
         if (bus.avm_rvalid) begin
            if (tq.size() > 0) begin
               t = tq.pop_front();
               e_valid[t] = 1'b1;
               m_data = bus.avm_rdata;
            end else begin
               m_err = 1;
            end
         end
         if (push) tq.push_back(m_tag);
      end
      @(posedge clk);
      @(negedge clk);
      check("wr_ack",   bus.o_wr_ack,     e_wr_ack);
      check("rd_ack",   bus.o_rd_ack,     e_rd_ack);
      check("cs",       bus.avm_cs,       m_busy);
      check("read_n",   bus.avm_read_n,   !(m_busy && m_is_rd));
      check("write_n",  bus.avm_write_n,  !(m_busy && !m_is_rd));
      check("byteen_n", bus.avm_byteen_n, 4'b0000);
      check("rd_valid", bus.o_rd_valid,   e_valid);
      check("err",      bus.o_err,        m_err);
      if (m_busy) check("addr", bus.avm_address, m_addr);
      if (m_busy && !m_is_rd) check("wdata", bus.avm_wdata, m_wdata);
      if (e_valid != '0) check("rd_data", bus.o_rd_data, m_data);
      if (was_rst) begin
         check("rst_addr",    bus.avm_address, 23'h0);
         check("rst_wdata",   bus.avm_wdata,   32'h0);
         check("rst_rd_data", bus.o_rd_data,   32'h0);
      end
      if (bus.avm_cs) cs_cycles++;
   endtask

   // Requester stand-ins: log acks, then re-arm, raise or drop per the knobs.
   task automatic agents();
      logic [31:0] r;
      if (bus.o_wr_ack) begin
         ack_log.push_back(N_RD);
         if ($urandom_range(0, 99) < w_rearm) begin
            r = $urandom; bus.i_wr_addr = r[AW-1:0]; bus.i_wr_data = $urandom;
         end else begin
            bus.i_wr_req = 1'b0;
         end
      end else if (!bus.i_wr_req) begin
         if ($urandom_range(0, 99) < p_raise) begin
            r = $urandom; bus.i_wr_addr = r[AW-1:0]; bus.i_wr_data = $urandom;
            bus.i_wr_req = 1'b1;
         end
      end else if ($urandom_range(0, 99) < p_drop) begin
         bus.i_wr_req = 1'b0;
      end
      for (int k = 0; k < N_RD; k++) begin
         if (bus.o_rd_ack[k]) begin
            ack_log.push_back(k);
            if ($urandom_range(0, 99) < r_rearm) begin
               r = $urandom; bus.i_rd_addr[k*AW +: AW] = r[AW-1:0];
            end else begin
               bus.i_rd_req[k] = 1'b0;
            end
         end else if (!bus.i_rd_req[k]) begin
            if ($urandom_range(0, 99) < p_raise) begin
               r = $urandom; bus.i_rd_addr[k*AW +: AW] = r[AW-1:0];
               bus.i_rd_req[k] = 1'b1;
            end
         end else if ($urandom_range(0, 99) < p_drop) begin
            bus.i_rd_req[k] = 1'b0;
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         agents();
      end
   endtask

   task automatic reset_all();
      bus.i_wr_req = 1'b0; bus.i_rd_req = '0;
      bus.avm_wait = 1'b0; bus.avm_rvalid = 1'b0; bus.avm_rdata = '0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      ack_log.delete();
      cs_cycles = 0;
      w_rearm = 0; r_rearm = 0; p_raise = 0; p_drop = 0;
   endtask

   function automatic int n_rd_acks();
      int n = 0;
      foreach (ack_log[i]) if (ack_log[i] < N_RD) n++;
      return n;
   endfunction

   function automatic int n_wr_acks();
      int n = 0;
      foreach (ack_log[i]) if (ack_log[i] == N_RD) n++;
      return n;
   endfunction

   initial begin
      logic [31:0] r;
      bus.i_wr_req = 1'b0; bus.i_wr_addr = '0; bus.i_wr_data = '0;
      bus.i_rd_req = '0;   bus.i_rd_addr = '0;
      bus.avm_rdata = '0;  bus.avm_rvalid = 1'b0; bus.avm_wait = 1'b0;
      @(negedge clk);

      // reset held two cycles, then one idle cycle
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      ack_log.delete(); cs_cycles = 0;
      w_rearm = 0; r_rearm = 0; p_raise = 0; p_drop = 0;
      run(1);

      // single write, no wait states
      reset_all();
      bus.i_wr_addr = 23'h10; bus.i_wr_data = 32'hDEADBEEF; bus.i_wr_req = 1'b1;
      run(4);
      check("t2_acks", ack_log.size(), 1);
      check("t2_cs_cycles", cs_cycles, 1);

      // single write, three wait cycles
      reset_all();
      bus.avm_wait = 1'b1;
      bus.i_wr_addr = 23'h10; bus.i_wr_data = 32'hDEADBEEF; bus.i_wr_req = 1'b1;
      run(4);
      bus.avm_wait = 1'b0;
      run(2);
      check("t3_acks", ack_log.size(), 1);
      check("t3_cs_cycles", cs_cycles, 4);

      // all readers: rotation, pending limit, write while full, returns
      reset_all();
      r_rearm = 100;
      for (int k = 0; k < N_RD; k++) begin
         r = $urandom; bus.i_rd_addr[k*AW +: AW] = r[AW-1:0];
      end
      bus.i_rd_req = 3'b111;
      run(12);
      check("t4_nreads", ack_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < ack_log.size()) check("t4_order", ack_log[i], exp4[i]);
      end
      bus.i_wr_addr = 23'h55; bus.i_wr_data = 32'h0BADF00D; bus.i_wr_req = 1'b1;
      run(4);
      check("t5_wr_when_full", n_wr_acks(), 1);
      check("t5_still_stalled", n_rd_acks(), 4);
      bus.avm_rvalid = 1'b1; bus.avm_rdata = 32'd123546464;
      run(1);
      check("t4_valid0", bus.o_rd_valid, 3'b001);
      check("t4_data0", bus.o_rd_data, 32'd123546464);
      bus.avm_rdata = 32'h5555AAAA;
      run(1);
      check("t4_valid1", bus.o_rd_valid, 3'b010);
      bus.avm_rvalid = 1'b0;
      run(8);
      check("t5_refill", n_rd_acks(), 6);

      // writer and reader 0 both continuous
      reset_all();
      w_rearm = 100; r_rearm = 100;
      bus.i_wr_addr = 23'h7; bus.i_wr_data = 32'h12345678;
      bus.i_wr_req = 1'b1; bus.i_rd_req = 3'b001;
      run(12);
`ifdef SDRAM_ARB_WR_FAIR_EN
      check("t6_wr", n_wr_acks(), 3);
      check("t6_rd", n_rd_acks(), 3);
      if (ack_log.size() > 1) check("t6_first", ack_log[0], 0);
      if (ack_log.size() > 1) check("t6_second", ack_log[1], N_RD);
`else
      check("t6_wr", n_wr_acks(), 6);
      check("t6_rd", n_rd_acks(), 0);
`endif

      // return with nothing outstanding
      reset_all();
      bus.avm_rvalid = 1'b1; bus.avm_rdata = 32'hCAFE0001;
      run(1);
      check("t7_err", bus.o_err, 1'b1);
      check("t7_valid", bus.o_rd_valid, 3'b000);
      bus.avm_rvalid = 1'b0;
      run(2);
      check("t7_sticky", bus.o_err, 1'b1);
      reset_all();
      check("t7_clear", bus.o_err, 1'b0);

      // randomized traffic with one reset in the middle
      reset_all();
      w_rearm = 40; r_rearm = 50; p_raise = 15; p_drop = 3;
      for (int i = 0; i < 3000; i++) begin
         bus.avm_wait = ($urandom_range(0, 3) == 0);
         if (tq.size() > 0 && $urandom_range(0, 2) == 0) begin
            bus.avm_rvalid = 1'b1; bus.avm_rdata = $urandom;
         end else begin
            bus.avm_rvalid = 1'b0;
         end
         rst = (i == 1500);
         step();
         rst = 1'b0;
         agents();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
